// File: rtl/alu_accumulator.sv
// alu_accumulator: accumulator-based ALU fed from the register-select bus mux.
// Operand A is the accumulator (AC), operand B is bus_in. Single-cycle ops
// write AC at the accept edge; MUL runs a MUL_STEPS-step shift-add sequence
// with a busy/done handshake.
// Optional feature macro: ALU_CARRY_FLAG_EN adds the registered carry output
// and widens the multiply datapath to keep the product's upper half.
module alu_accumulator #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MUL_STEPS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] ac_out,
  output logic             busy,
  output logic             done,
  output logic             zero
`ifdef ALU_CARRY_FLAG_EN
  ,
  output logic             carry
`endif
);

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_INC  = 3'b011,
    OP_CLR  = 3'b100,
    OP_MUL  = 3'b101,
    OP_SHL  = 3'b110,
    OP_SHR  = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  // Product width: the full 2*WIDTH product only matters for the carry flag.
`ifdef ALU_CARRY_FLAG_EN
  localparam int unsigned PW = 2 * WIDTH;
`else
  localparam int unsigned PW = WIDTH;
`endif
  localparam int unsigned CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_STEPS - 1);

  state_e          state_q;
  logic [WIDTH-1:0] ac_q;
  logic             busy_q;
  logic             done_q;
  logic             zero_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    prod_q;
  logic [CW-1:0]    cnt_q;
`ifdef ALU_CARRY_FLAG_EN
  logic             carry_q;
`endif

  // Bit WIDTH carries the carry/borrow/shifted-out bit for the single-cycle ops
  logic [WIDTH:0]   alu_res_d;
  logic [PW-1:0]    prod_d;

  // Single-cycle ALU result from the current AC and bus word
  always_comb begin
    alu_res_d = '0;
    case (op_e'(alu_op))
      OP_PASS: alu_res_d = {1'b0, bus_in};
      OP_ADD:  alu_res_d = {1'b0, ac_q} + {1'b0, bus_in};
      OP_SUB:  alu_res_d = {1'b0, ac_q} - {1'b0, bus_in};
      OP_INC:  alu_res_d = {1'b0, ac_q} + (WIDTH+1)'(1);
      OP_CLR:  alu_res_d = '0;
      OP_SHL:  alu_res_d = {ac_q, 1'b0};
      OP_SHR:  alu_res_d = {ac_q[0], 1'b0, ac_q[WIDTH-1:1]};
      default: alu_res_d = '0;
    endcase
  end

  // One shift-add step: the final step's sum is written straight into AC
  always_comb begin
    prod_d = prod_q;
    if (mplier_q[0]) prod_d = prod_q + mcand_q;
  end

`ifndef ALU_CARRY_FLAG_EN
  logic unused_carry;
  assign unused_carry = alu_res_d[WIDTH];
`endif

  // Control FSM, accumulator and flag registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ac_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b1;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
`ifdef ALU_CARRY_FLAG_EN
      carry_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (op_e'(alu_op) == OP_MUL) begin
              mcand_q  <= PW'(bus_in);
              mplier_q <= ac_q;
              prod_q   <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= S_MUL;
            end else begin
              ac_q   <= alu_res_d[WIDTH-1:0];
              zero_q <= (alu_res_d[WIDTH-1:0] == '0);
              done_q <= 1'b1;
`ifdef ALU_CARRY_FLAG_EN
              carry_q <= alu_res_d[WIDTH];
`endif
            end
          end
        end
        S_MUL: begin
          done_q   <= 1'b0;
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            ac_q    <= prod_d[WIDTH-1:0];
            zero_q  <= (prod_d[WIDTH-1:0] == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
`ifdef ALU_CARRY_FLAG_EN
            carry_q <= |prod_d[PW-1:WIDTH];
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ac_out = ac_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign zero   = zero_q;
`ifdef ALU_CARRY_FLAG_EN
  assign carry  = carry_q;
`endif

endmodule

// File: tb/tb_alu_accumulator.sv
// Self-checking bench for alu_accumulator. Expected results come from a
// behavioural model (plain arithmetic, A*B for MUL) and are queued at issue
// time, then popped when done is observed.
module tb_alu_accumulator;

  localparam logic [2:0] PASS = 3'd0, ADD = 3'd1, SUB = 3'd2, INC = 3'd3,
                         CLR  = 3'd4, MUL = 3'd5, SHL = 3'd6, SHR = 3'd7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  alu_op = 3'd0;
  logic [15:0] bus_in = 16'd0;
  logic [15:0] ac_out;
  logic        busy, done, zero;
`ifdef ALU_CARRY_FLAG_EN
  logic        carry;
`endif

  typedef struct packed {
    logic [15:0] ac;
    logic        z;
    logic        c;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_ac = 16'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  alu_accumulator #(.WIDTH(16), .MUL_STEPS(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .alu_op  (alu_op),
    .bus_in  (bus_in),
    .ac_out  (ac_out),
    .busy    (busy),
    .done    (done),
    .zero    (zero)
`ifdef ALU_CARRY_FLAG_EN
    ,
    .carry   (carry)
`endif
  );

  always #5 clk = ~clk;

  // Drive one accepted request, update the model and queue its result.
  // Returns at accept-edge + 1.
  task automatic issue(input logic [2:0] op, input logic [15:0] b);
    exp_t        e;
    logic [16:0] s;
    logic [31:0] p;
    @(negedge clk);
    start = 1'b1; alu_op = op; bus_in = b;
    e = '0;
    case (op)
      PASS: begin e.ac = b; e.c = 1'b0; end
      ADD:  begin s = {1'b0, model_ac} + {1'b0, b}; e.ac = s[15:0]; e.c = s[16]; end
      SUB:  begin e.ac = model_ac - b; e.c = (model_ac < b); end
      INC:  begin e.ac = model_ac + 16'd1; e.c = (model_ac == 16'hFFFF); end
      CLR:  begin e.ac = 16'd0; e.c = 1'b0; end
      MUL:  begin p = 32'(model_ac) * 32'(b); e.ac = p[15:0]; e.c = |p[31:16]; end
      SHL:  begin e.ac = model_ac << 1; e.c = model_ac[15]; end
      default: begin e.ac = model_ac >> 1; e.c = model_ac[0]; end
    endcase
    e.z = (e.ac == 16'd0);
    model_ac = e.ac;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges after the accept edge until done is seen (bounded).
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0; busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    int dn;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ac_out !== 16'd0) begin n_fail++; $display("FAIL reset_ac got=%h exp=0000", ac_out); end
    n_checks++; if ({busy, done, zero} !== 3'b001) begin n_fail++; $display("FAIL reset_flags busy/done/zero got=%b exp=001", {busy, done, zero}); end
    @(negedge clk); reset_n = 1'b1;
    issue(PASS, 16'h1234);
    void'(exp_q.pop_front());
    // start a MUL and kill it with reset mid-flight
    @(negedge clk); start = 1'b1; alu_op = MUL; bus_in = 16'h0003;
    @(posedge clk); #1; start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_mul_busy got=%b exp=1", busy); end
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ac_out !== 16'd0) begin n_fail++; $display("FAIL reset_mid_ac got=%h exp=0000", ac_out); end
    n_checks++; if ({busy, done, zero} !== 3'b001) begin n_fail++; $display("FAIL reset_mid_flags got=%b exp=001", {busy, done, zero}); end
    @(negedge clk); reset_n = 1'b1;
    model_ac = 16'd0;
    exp_q.delete();
    dn = 0;
    repeat (20) begin @(posedge clk); #1; if (done) dn++; end
    n_checks++; if (dn !== 0 || ac_out !== 16'd0) begin n_fail++; $display("FAIL reset_no_done dones=%0d ac=%h exp=0,0000", dn, ac_out); end
  endtask

  task automatic test_single_cycle();
    int   lat, bn;
    exp_t e;
    issue(PASS, 16'h0005);
    wait_done(lat, bn);
    e = exp_q.pop_front();
    n_checks++; if (lat !== 0 || ac_out !== e.ac) begin n_fail++; $display("FAIL pass5 lat=%0d ac=%h exp lat=0 ac=%h", lat, ac_out, e.ac); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL pass5_done_pulse got=%b exp=0", done); end
    issue(ADD, 16'h0003);
    wait_done(lat, bn);
    e = exp_q.pop_front();
    n_checks++; if (lat !== 0 || ac_out !== 16'h0008 || ac_out !== e.ac) begin n_fail++; $display("FAIL add3 lat=%0d ac=%h exp lat=0 ac=0008", lat, ac_out); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add3_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_random_ops();
    int          lat, bn;
    exp_t        e;
    logic [2:0]  op;
    logic [15:0] b;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == MUL) op = SHL;
      b = (i % 4 == 0) ? 16'hFFFF : 16'($urandom);
      issue(op, b);
      wait_done(lat, bn);
      e = exp_q.pop_front();
      n_checks++;
      if (lat !== 0 || ac_out !== e.ac || zero !== e.z) begin
        n_fail++; $display("FAIL rand_op%0d op=%0d lat=%0d ac=%h z=%b exp ac=%h z=%b", i, op, lat, ac_out, zero, e.ac, e.z);
      end
`ifdef ALU_CARRY_FLAG_EN
      n_checks++; if (carry !== e.c) begin n_fail++; $display("FAIL rand_carry%0d op=%0d got=%b exp=%b", i, op, carry, e.c); end
`endif
    end
  endtask

  task automatic test_wrap();
    int   lat, bn;
    exp_t e;
    issue(PASS, 16'h0000);
    void'(exp_q.pop_front());
    issue(SUB, 16'h0001);
    wait_done(lat, bn);
    e = exp_q.pop_front();
    n_checks++; if (ac_out !== 16'hFFFF || zero !== 1'b0 || e.ac !== 16'hFFFF) begin n_fail++; $display("FAIL sub_wrap ac=%h z=%b exp ac=ffff z=0", ac_out, zero); end
`ifdef ALU_CARRY_FLAG_EN
    n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL sub_borrow got=%b exp=1", carry); end
`endif
    issue(INC, 16'h5555);
    wait_done(lat, bn);
    e = exp_q.pop_front();
    n_checks++; if (ac_out !== 16'h0000 || zero !== 1'b1 || e.ac !== 16'h0000) begin n_fail++; $display("FAIL inc_wrap ac=%h z=%b exp ac=0000 z=1", ac_out, zero); end
`ifdef ALU_CARRY_FLAG_EN
    n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL inc_carry got=%b exp=1", carry); end
`endif
  endtask

  task automatic test_mul();
    int   lat, bn, dn;
    exp_t e;
    issue(PASS, 16'h0012);
    void'(exp_q.pop_front());
    issue(MUL, 16'h0034);
    n_checks++; if (busy !== 1'b1 || done !== 1'b0 || ac_out !== 16'h0012) begin n_fail++; $display("FAIL mul_accept busy=%b done=%b ac=%h exp 1,0,0012", busy, done, ac_out); end
    bus_in = 16'hBEEF;
    wait_done(lat, bn);
    e = exp_q.pop_front();
    n_checks++; if (lat !== 16 || bn !== 16) begin n_fail++; $display("FAIL mul_timing lat=%0d busy_cycles=%0d exp 16,16", lat, bn); end
    n_checks++; if (ac_out !== 16'h03A8 || e.ac !== 16'h03A8 || zero !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mul_result ac=%h z=%b busy=%b exp 03a8,0,0", ac_out, zero, busy); end
`ifdef ALU_CARRY_FLAG_EN
    n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL mul_carry got=%b exp=0", carry); end
`endif
    dn = 0;
    repeat (4) begin @(posedge clk); #1; if (done) dn++; end
    n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL mul_single_done extra=%0d exp=0", dn); end
  endtask

  task automatic test_mul_overflow_ignore();
    int   lat, dn;
    exp_t e;
    issue(PASS, 16'h1000);
    void'(exp_q.pop_front());
    issue(MUL, 16'h0010);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk); start = lat[0]; alu_op = ADD; bus_in = 16'h0001;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    n_checks++; if (lat !== 16 || ac_out !== 16'h0000 || zero !== 1'b1 || e.ac !== 16'h0000) begin n_fail++; $display("FAIL mul_ovf lat=%0d ac=%h z=%b exp 16,0000,1", lat, ac_out, zero); end
`ifdef ALU_CARRY_FLAG_EN
    n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL mul_ovf_carry got=%b exp=1", carry); end
`endif
    dn = 0;
    repeat (4) begin @(posedge clk); #1; if (done) dn++; end
    n_checks++; if (dn !== 0 || ac_out !== 16'h0000) begin n_fail++; $display("FAIL mul_ignore dones=%0d ac=%h exp 0,0000", dn, ac_out); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] vals [3];
    logic [2:0]  ops  [3];
    ops[0] = PASS; vals[0] = 16'h0007;
    ops[1] = ADD;  vals[1] = 16'h0001;
    ops[2] = ADD;  vals[2] = 16'hFFF8;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], vals[i]);
      e = exp_q.pop_front();
      n_checks++; if (done !== 1'b1 || ac_out !== e.ac || zero !== e.z) begin n_fail++; $display("FAIL b2b_%0d done=%b ac=%h z=%b exp 1,%h,%b", i, done, ac_out, zero, e.ac, e.z); end
    end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0 || ac_out !== 16'h0000) begin n_fail++; $display("FAIL b2b_end done=%b ac=%h exp 0,0000", done, ac_out); end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_wrap();
    test_random_ops();
    test_mul();
    test_mul_overflow_ignore();
    test_back_to_back();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
